// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the 7-segment scan driver.
//   - 7-segment encodings for BCD digits 0..9 (bit7..bit0 = a,b,c,d,e,f,g,dp)
//   - blank pattern, digit count, converter FSM state type
//   - seg_encode(): BCD digit to segment pattern
//   - bcd_adjust(): the add-3 step of double dabble over all BCD digits
`timescale 1ns/1ps
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  // Any BCD digit >= 5 gets +3 so that the following left shift carries
  // correctly into the next decimal digit.
  function automatic logic [4*NUM_DIGITS-1:0] bcd_adjust(input logic [4*NUM_DIGITS-1:0] bcd);
    logic [4*NUM_DIGITS-1:0] result;
    logic [3:0] nib;
    result = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = bcd[4*i +: 4];
      result[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: value handshake and display outputs of the scan driver.
//   value       [W-1:0]  unsigned number to display
//   value_valid          value offered this cycle
//   value_ready          driver can accept a value this cycle
//   segment     [7:0]    active-high segments a..g,dp (bit7..bit0)
//   ctrl        [3:0]    active-low digit enables, ctrl[3-k] selects digit k
// master = value producer, slave = scan driver.
`timescale 1ns/1ps
interface seg_scan_driver_if #(
  parameter int W = 10
);
  logic [W-1:0] value;
  logic         value_valid;
  logic         value_ready;
  logic [7:0]   segment;
  logic [3:0]   ctrl;

  modport master (
    output value,
    output value_valid,
    input  value_ready,
    input  segment,
    input  ctrl
  );

  modport slave (
    input  value,
    input  value_valid,
    output value_ready,
    output segment,
    output ctrl
  );
endinterface

// File: rtl/seg_bin2bcd.sv
// seg_bin2bcd: sequential binary-to-BCD converter (double dabble).
//   clk, reset : clock, asynchronous active-high reset
//   start      : value offered; taken only while ready=1
//   bin        : binary input, W bits
//   ready      : 1 in IDLE only
//   commit     : 1 for the single COMMIT cycle; bcd is final then
//   bcd        : four BCD digits, units in bcd[3:0]
// IDLE -> SHIFT (W cycles, one bit per cycle, MSB first) -> COMMIT -> IDLE.
`timescale 1ns/1ps
module seg_bin2bcd
  import seg_pkg::*;
#(
  parameter int W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W-1:0]            bin,
  output logic                    ready,
  output logic                    commit,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(W);

  state_t          state_reg, state_next;
  logic [BW+W-1:0] shift_reg, shift_next;
  logic [CW-1:0]   cnt_reg;

  // Combined register: BCD digits on top, remaining binary bits below.
  always_comb begin
    shift_next = {bcd_adjust(shift_reg[BW+W-1:W]), shift_reg[W-1:0]} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        shift_reg <= {{BW{1'b0}}, bin};
        cnt_reg   <= '0;
      end else if (state_reg == SHIFT) begin
        shift_reg <= shift_next;
        cnt_reg   <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    commit     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt_reg == CW'(W - 1)) state_next = COMMIT;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bcd = shift_reg[BW+W-1:W];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: accepts a binary value, converts it to 4 BCD digits and
// multiplexes them onto a 4-digit common 7-segment display.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : seg_scan_driver_if.slave (value/value_valid/value_ready,
//           segment, ctrl)
// Parameters: W (input width 4..13), SCAN_DIV (clk cycles per digit, >= 2).
// Build option: define SEG_LZ_BLANK_EN to blank leading zero digits
// (units digit always shown); scanning of ctrl is the same in both builds.
`timescale 1ns/1ps
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int W        = 10,
  parameter int SCAN_DIV = 2000
) (
  input  logic               clk,
  input  logic               reset,
  seg_scan_driver_if.slave   bus
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(SCAN_DIV);

  logic          conv_ready;
  logic          conv_commit;
  logic [BW-1:0] conv_bcd;

  logic [BW-1:0] disp_reg;
  logic [PW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  logic [7:0]    seg_reg;
  logic [3:0]    ctrl_reg;
  logic          tick;
  logic [7:0]    enc [NUM_DIGITS];

  seg_bin2bcd #(.W(W)) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.value_valid),
    .bin    (bus.value),
    .ready  (conv_ready),
    .commit (conv_commit),
    .bcd    (conv_bcd)
  );

  assign tick = (presc_reg == PW'(SCAN_DIV - 1));

  // Per-digit segment patterns from the committed display register only,
  // so a conversion in flight is never visible.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_enc
      if (gi == 0) begin : g_units
        assign enc[gi] = seg_encode(disp_reg[3:0]);
      end else begin : g_upper
`ifdef SEG_LZ_BLANK_EN
        // Blank when this digit and every higher digit are zero.
        assign enc[gi] = (disp_reg[BW-1:4*gi] == '0) ? SEG_BLANK
                                                     : seg_encode(disp_reg[4*gi +: 4]);
`else
        assign enc[gi] = seg_encode(disp_reg[4*gi +: 4]);
`endif
      end
    end
  endgenerate

  // idx_reg is the digit driven at the next tick; it starts at 0 so the
  // first tick lights the units digit. A tick coinciding with COMMIT still
  // reads the old disp_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_reg  <= '0;
      presc_reg <= '0;
      idx_reg   <= 2'd0;
      seg_reg   <= SEG_BLANK;
      ctrl_reg  <= 4'b1111;
    end else begin
      if (conv_commit) disp_reg <= conv_bcd;
      if (tick) begin
        presc_reg <= '0;
        idx_reg   <= idx_reg + 2'd1;
        seg_reg   <= enc[idx_reg];
        ctrl_reg  <= ~(4'b1000 >> idx_reg);
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

  assign bus.value_ready = conv_ready;
  assign bus.segment     = seg_reg;
  assign bus.ctrl        = ctrl_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
module tb_seg_scan_driver;

  localparam int W        = 10;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.W(W)) bus ();

  seg_scan_driver #(.W(W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         tick;
    logic [3:0] ctrl;
    logic [7:0] seg;
    int         val;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         tick_count = 0;
  logic [3:0] prev_ctrl = 4'hF;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hFC;
      1: return 8'h60;
      2: return 8'hDA;
      3: return 8'hF2;
      4: return 8'h66;
      5: return 8'hB6;
      6: return 8'hBE;
      7: return 8'hE0;
      8: return 8'hFE;
      9: return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
`ifdef SEG_LZ_BLANK_EN
    if (k > 0 && v < p) return 8'h00;
`endif
    return seg_of((v / p) % 10);
  endfunction

  // Monitor: every change of ctrl is one scan tick; compare against the
  // scoreboard entry registered for that tick number.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      tick_count = 0;
      prev_ctrl  = 4'hF;
    end else if (bus.ctrl !== prev_ctrl) begin
      prev_ctrl = bus.ctrl;
      tick_count++;
      while (q.size() > 0 && q[0].tick < tick_count) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_tick tick=%0d val=%0d not observed", e.tick, e.val);
      end
      if (q.size() > 0 && q[0].tick == tick_count) begin
        e = q.pop_front();
        checks++;
        if (bus.ctrl !== e.ctrl || bus.segment !== e.seg) begin
          errors++;
          $display("FAIL scan tick=%0d val=%0d got ctrl=%b seg=%h expected ctrl=%b seg=%h",
                   tick_count, e.val, bus.ctrl, bus.segment, e.ctrl, e.seg);
        end else begin
          $display("PASS scan tick=%0d val=%0d ctrl=%b seg=%h",
                   tick_count, e.val, bus.ctrl, bus.segment);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end else begin
      $display("PASS %s value=%0h", name, act);
    end
  endtask

  // Push expectations for n consecutive ticks starting at tick number first.
  task automatic push_display(input int v, input int n, input int first);
    exp_t       e;
    logic [3:0] one_hot;
    int         k;
    one_hot = 4'b1000;
    for (int i = 0; i < n; i++) begin
      e.tick = first + i;
      k      = (e.tick - 1) % 4;
      e.ctrl = ~(one_hot >> k);
      e.seg  = exp_seg(v, k);
      e.val  = v;
      q.push_back(e);
    end
  endtask

  // Settle past the monitor's negedge so tick_count includes the last edge.
  task automatic sync(output int base);
    @(negedge clk);
    #1;
    base = tick_count;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout pending=%0d", name, q.size());
      q.delete();
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.value_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.value_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s ready_timeout got=%b expected=1", name, bus.value_ready);
    end
  endtask

  // Offer v until accepted, then count cycles with value_ready low.
  task automatic send(input int v, output int low);
    int n;
    @(negedge clk);
    bus.value       = W'(v);
    bus.value_valid = 1'b1;
    n = 0;
    while (bus.value_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.value_valid = 1'b0;
    low = 0;
    while (bus.value_ready !== 1'b1 && low < 100) begin
      low++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    int low;
    int cyc;
    logic [3:0] c0;

    bus.value       = '0;
    bus.value_valid = 1'b0;
    reset           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_ctrl", 32'(bus.ctrl), 32'h0000000F);
    chk("reset_segment", 32'(bus.segment), 32'h0);
    chk("reset_ready", 32'(bus.value_ready), 32'h1);

    push_display(0, 4, 1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (bus.ctrl === 4'hF && cyc < 100);
    chk("first_tick_cycles", 32'(cyc), 32'(SCAN_DIV));
    wait_empty("reset_scan");

    send(11, low);
    chk("ready_low_cycles_11", 32'(low), 32'(W + 1));
    sync(base);
    push_display(11, 4, base + 1);
    wait_empty("value_11");

    send(1023, low);
    chk("ready_low_cycles_1023", 32'(low), 32'(W + 1));
    sync(base);
    push_display(1023, 8, base + 1);
    wait_empty("value_1023");

    // 5 accepted, 7 offered while busy must be ignored until ready returns.
    @(negedge clk);
    bus.value       = W'(5);
    bus.value_valid = 1'b1;
    cyc = 0;
    while (bus.value_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    bus.value = W'(7);
    chk("busy_ready_low", 32'(bus.value_ready), 32'h0);
    wait_ready("commit_5");
    sync(base);
    push_display(5, 3, base + 1);
    @(posedge clk);
    #1;
    bus.value_valid = 1'b0;
    chk("second_value_taken", 32'(bus.value_ready), 32'h0);
    wait_ready("commit_7");
    sync(base);
    push_display(7, 4, base + 1);
    wait_empty("back_to_back");

    // Reset in the middle of converting 999.
    @(negedge clk);
    bus.value       = W'(999);
    bus.value_valid = 1'b1;
    cyc = 0;
    while (bus.value_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    bus.value_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midshift_reset_ready", 32'(bus.value_ready), 32'h1);
    chk("midshift_reset_ctrl", 32'(bus.ctrl), 32'h0000000F);
    sync(base);
    push_display(0, 4, base + 1);
    wait_empty("after_reset_zero");

    send(999, low);
    chk("ready_low_cycles_999", 32'(low), 32'(W + 1));
    sync(base);
    push_display(999, 4, base + 1);
    wait_empty("value_999");

    // Align acceptance one edge after a tick so COMMIT lands on a tick.
    c0  = bus.ctrl;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (bus.ctrl === c0 && cyc < 100);
    sync(base);
    chk("idle_before_coincide", 32'(bus.value_ready), 32'h1);
    bus.value       = W'(42);
    bus.value_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.value_valid = 1'b0;
    push_display(999, 3, base + 1);
    push_display(42, 4, base + 4);
    wait_ready("commit_42");
    wait_empty("coincide");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
